// File: rtl/config_shift_receiver.sv
// config_shift_receiver: receiving end of the 3-wire serial configuration link.
// Latency: pins -> edge detect 2 clk; cfg_en fall at pin -> commit/error pulse 3 clk.
// Backpressure: none; the serial master owns the pace.
// Optional build macro: CFG_RX_READBACK_EN (readback of the committed word on cfg_dout).
module config_shift_receiver #(
  parameter int               WIDTH       = 33,
  parameter logic [WIDTH-1:0] DEFAULT_CFG = WIDTH'(33'h03CF10404)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic             cfg_sclk,
  input  logic             cfg_data,
  output logic [WIDTH-1:0] config_out,
  output logic             config_valid,
  output logic             config_loaded,
  output logic             frame_error,
  output logic             cfg_dout
);

  // Count must hold WIDTH+1 (the saturation value) without wrapping.
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Synchroniser chains. Index 1 is the synced value, index 2 the extra
  // registered copy used only for edge detection. All three inputs use the
  // same depth so data stays aligned with the sclk edge that samples it.
  logic [2:0] en_sync;
  logic [2:0] sclk_sync;
  logic [1:0] data_sync;

  logic       en_s;
  logic       en_rise;
  logic       en_fall;
  logic       sclk_rise;
  logic       data_s;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic             commit;
  logic             bad_frame;

  // Bring the asynchronous link pins into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_sync   <= '0;
      sclk_sync <= '0;
      data_sync <= '0;
    end else begin
      en_sync   <= {en_sync[1:0], cfg_en};
      sclk_sync <= {sclk_sync[1:0], cfg_sclk};
      data_sync <= {data_sync[0], cfg_data};
    end
  end

  assign en_s      = en_sync[1];
  assign en_rise   = en_sync[1] & ~en_sync[2];
  assign en_fall   = ~en_sync[1] & en_sync[2];
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign data_s    = data_sync[1];

  // Frame FSM: next state, shift register and bit counter.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    sr_nxt    = sr;
    commit    = 1'b0;
    bad_frame = 1'b0;
    case (state)
      ST_IDLE: begin
        // sclk activity outside a frame is ignored.
        if (en_rise) begin
          state_nxt = ST_SHIFT;
          count_nxt = '0;
`ifdef CFG_RX_READBACK_EN
          // Preload the committed word so it streams out while the new one streams in.
          sr_nxt    = config_out;
`else
          sr_nxt    = '0;
`endif
        end
      end
      ST_SHIFT: begin
        if (en_fall) begin
          // An sclk edge landing in the same synced cycle as the en fall is
          // dropped; the frame is judged on the bits already counted.
          state_nxt = ST_IDLE;
          if (count == CNT_FULL) begin
            commit = 1'b1;
          end else begin
            bad_frame = 1'b1;
          end
        end else if (sclk_rise && en_s) begin
          // LSB first: after WIDTH edges sr[0] holds the first bit sent.
          sr_nxt = {data_s, sr[WIDTH-1:1]};
          if (count != CNT_SAT) begin
            count_nxt = count + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      sr    <= sr_nxt;
    end
  end

  // Committed configuration word and its status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      config_out    <= DEFAULT_CFG;
      config_valid  <= 1'b0;
      config_loaded <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      config_valid <= commit;
      frame_error  <= bad_frame;
      if (commit) begin
        config_out    <= sr;
        config_loaded <= 1'b1;
      end
    end
  end

`ifdef CFG_RX_READBACK_EN
  // Readback: registered sr[0] while a frame is open, quiet otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_dout <= 1'b0;
    end else begin
      cfg_dout <= (state == ST_SHIFT) ? sr[0] : 1'b0;
    end
  end
`else
  assign cfg_dout = 1'b0;
`endif

endmodule
